// File: rtl/sync_pkg.sv
// Shared types and constants for the sync link receiver.
package sync_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } sync_state_t;

   localparam int SYNC_DEFAULT_PERIOD = 4;
   localparam int ERR_CNT_W           = 16;

endpackage

// File: rtl/sync_lock.sv
// Sync pulse tracker: hunts for a pulse, verifies the period, locks and flywheels a frame phase.
// Optional build macro SYNC_LOCK_STATS_EN adds a saturating err_count output.
module sync_lock
   import sync_pkg::*;
#(
   parameter int PERIOD     = SYNC_DEFAULT_PERIOD,
   parameter int LOCK_COUNT = 3,
   parameter int MISS_LIMIT = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      sync_in,
   output logic                      locked,
   output logic [$clog2(PERIOD)-1:0] phase,
   output logic                      frame_start,
   output logic                      err
`ifdef SYNC_LOCK_STATS_EN
   ,
   output logic [ERR_CNT_W-1:0]      err_count
`endif
);

   localparam int PH_W = $clog2(PERIOD);
   localparam int GC_W = $clog2(LOCK_COUNT + 1);
   localparam int MC_W = $clog2(MISS_LIMIT + 1);

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);
   localparam logic [GC_W-1:0] GC_DONE = GC_W'(LOCK_COUNT);
   localparam logic [MC_W-1:0] MC_DONE = MC_W'(MISS_LIMIT);

   sync_state_t     state;
   sync_state_t     state_nx;
   logic [PH_W-1:0] phase_nx;
   logic [GC_W-1:0] good_cnt;
   logic [GC_W-1:0] good_nx;
   logic [GC_W-1:0] good_inc;
   logic [MC_W-1:0] miss_cnt;
   logic [MC_W-1:0] miss_nx;
   logic [MC_W-1:0] miss_inc;
   logic            exp_hit;
   logic            anchor;

   assign exp_hit     = (phase == PH_LAST);
   assign good_inc    = good_cnt + GC_W'(1);
   assign miss_inc    = miss_cnt + MC_W'(1);
   assign frame_start = en && (state == LOCKED) && exp_hit;
   assign err         = en && (state == LOCKED) && (sync_in ^ exp_hit);

   always_comb begin
      state_nx = state;
      good_nx  = good_cnt;
      miss_nx  = miss_cnt;
      anchor   = 1'b0;
      case (state)
         HUNT: begin
            if (sync_in) begin
               anchor = 1'b1;
               if (LOCK_COUNT == 1) begin
                  state_nx = LOCKED;
                  good_nx  = '0;
                  miss_nx  = '0;
               end else begin
                  state_nx = VERIFY;
                  good_nx  = GC_W'(1);
               end
            end
         end
         VERIFY: begin
            if (sync_in && exp_hit) begin
               if (good_inc == GC_DONE) begin
                  state_nx = LOCKED;
                  good_nx  = '0;
                  miss_nx  = '0;
               end else begin
                  good_nx = good_inc;
               end
            end else if (sync_in) begin
               // Misplaced pulse: treat it as a fresh anchor rather than giving up.
               anchor  = 1'b1;
               good_nx = GC_W'(1);
            end else if (exp_hit) begin
               state_nx = HUNT;
               good_nx  = '0;
            end
         end
         LOCKED: begin
            // No re-anchoring here; the phase flywheels through isolated faults.
            if (sync_in && exp_hit) begin
               miss_nx = '0;
            end else if (sync_in ^ exp_hit) begin
               if (miss_inc == MC_DONE) begin
                  state_nx = HUNT;
                  miss_nx  = '0;
               end else begin
                  miss_nx = miss_inc;
               end
            end
         end
         default: begin
            state_nx = HUNT;
            good_nx  = '0;
            miss_nx  = '0;
         end
      endcase
   end

   always_comb begin
      if (anchor || exp_hit) phase_nx = '0;
      else                   phase_nx = phase + PH_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= HUNT;
         phase    <= '0;
         good_cnt <= '0;
         miss_cnt <= '0;
         locked   <= 1'b0;
      end else if (en) begin
         state    <= state_nx;
         phase    <= phase_nx;
         good_cnt <= good_nx;
         miss_cnt <= miss_nx;
         locked   <= (state_nx == LOCKED);
      end
   end

`ifdef SYNC_LOCK_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_count <= '0;
      end else if (err && (err_count != {ERR_CNT_W{1'b1}})) begin
         err_count <= err_count + ERR_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_sync_lock.sv
// Directed bench for sync_lock with PERIOD=4, LOCK_COUNT=3, MISS_LIMIT=2.
module tb_sync_lock;

   logic       clk;
   logic       rst;
   logic       en;
   logic       sync_in;
   logic       locked;
   logic [1:0] phase;
   logic       frame_start;
   logic       err;
`ifdef SYNC_LOCK_STATS_EN
   logic [15:0] err_count;
`endif

   int errors;
   int checks;

   logic       obs_err;
   logic       obs_fs;
   logic [1:0] obs_phase;

   sync_lock #(
      .PERIOD     (4),
      .LOCK_COUNT (3),
      .MISS_LIMIT (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .sync_in     (sync_in),
      .locked      (locked),
      .phase       (phase),
      .frame_start (frame_start),
      .err         (err)
`ifdef SYNC_LOCK_STATS_EN
      ,
      .err_count   (err_count)
`endif
   );

   always #5 clk = ~clk;

   // Called just after a rising edge: drive one cycle, capture mid-cycle outputs, cross the next edge.
   task automatic step(input logic s, input logic e);
      sync_in = s;
      en      = e;
      #2;
      obs_err   = err;
      obs_fs    = frame_start;
      obs_phase = phase;
      @(posedge clk);
      #1;
   endtask

   task automatic idle3(output int nfs, output int nerr);
      nfs  = 0;
      nerr = 0;
      repeat (3) begin
         step(1'b0, 1'b1);
         if (obs_fs)  nfs++;
         if (obs_err) nerr++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      en  = 1'b1;
      sync_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", locked); end
      checks++;
      if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
      checks++;
      if (frame_start !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL reset_outs: frame_start=%0b err=%0b expected 0 0", frame_start, err);
      end
`ifdef SYNC_LOCK_STATS_EN
      checks++;
      if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
`endif
      rst = 1'b1;
   endtask

   task automatic test_acquire();
      int nfs, nerr;
      repeat (3) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      checks++;
      if (obs_phase !== 2'd3) begin errors++; $display("FAIL hunt_freerun_phase: got %0d expected 3", obs_phase); end
      checks++;
      if (phase !== 2'd0 || locked !== 1'b0) begin
         errors++; $display("FAIL first_anchor: phase=%0d locked=%0b expected 0 0", phase, locked);
      end
      idle3(nfs, nerr);
      step(1'b1, 1'b1);
      checks++;
      if (obs_fs !== 1'b0 || locked !== 1'b0) begin
         errors++; $display("FAIL second_pulse: frame_start=%0b locked=%0b expected 0 0", obs_fs, locked);
      end
      idle3(nfs, nerr);
      step(1'b1, 1'b1);
      checks++;
      if (locked !== 1'b1 || phase !== 2'd0) begin
         errors++; $display("FAIL third_pulse_lock: locked=%0b phase=%0d expected 1 0", locked, phase);
      end
      idle3(nfs, nerr);
      checks++;
      if (nfs != 0 || nerr != 0) begin
         errors++; $display("FAIL locked_idle: frame_start count=%0d err count=%0d expected 0 0", nfs, nerr);
      end
      step(1'b1, 1'b1);
      checks++;
      if (obs_fs !== 1'b1 || obs_err !== 1'b0) begin
         errors++; $display("FAIL frame_start_coincident: frame_start=%0b err=%0b expected 1 0", obs_fs, obs_err);
      end
   endtask

   task automatic test_single_miss();
      int nfs, nerr;
      idle3(nfs, nerr);
      step(1'b0, 1'b1);
      checks++;
      if (obs_err !== 1'b1 || obs_fs !== 1'b1) begin
         errors++; $display("FAIL miss1_err: err=%0b frame_start=%0b expected 1 1", obs_err, obs_fs);
      end
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL miss1_locked: got %0b expected 1", locked); end
      idle3(nfs, nerr);
      step(1'b1, 1'b1);
      checks++;
      if (obs_err !== 1'b0 || locked !== 1'b1) begin
         errors++; $display("FAIL good_after_miss: err=%0b locked=%0b expected 0 1", obs_err, locked);
      end
      idle3(nfs, nerr);
      step(1'b0, 1'b1);
      checks++;
      if (obs_err !== 1'b1 || locked !== 1'b1) begin
         errors++; $display("FAIL miss_cnt_cleared: err=%0b locked=%0b expected 1 1", obs_err, locked);
      end
      idle3(nfs, nerr);
      step(1'b1, 1'b1);
      checks++;
      if (obs_err !== 1'b0) begin errors++; $display("FAIL recover_pulse_err: got %0b expected 0", obs_err); end
   endtask

   task automatic test_double_miss();
      int nfs, nerr;
      idle3(nfs, nerr);
      step(1'b0, 1'b1);
      checks++;
      if (obs_err !== 1'b1 || locked !== 1'b1) begin
         errors++; $display("FAIL dmiss1: err=%0b locked=%0b expected 1 1", obs_err, locked);
      end
      idle3(nfs, nerr);
      step(1'b0, 1'b1);
      checks++;
      if (obs_err !== 1'b1 || locked !== 1'b0) begin
         errors++; $display("FAIL dmiss2_unlock: err=%0b locked=%0b expected 1 0", obs_err, locked);
      end
      idle3(nfs, nerr);
      step(1'b0, 1'b1);
      checks++;
      if (obs_phase !== 2'd3 || obs_fs !== 1'b0 || obs_err !== 1'b0) begin
         errors++;
         $display("FAIL hunt_no_outputs: phase=%0d frame_start=%0b err=%0b expected 3 0 0", obs_phase, obs_fs, obs_err);
      end
   endtask

   task automatic test_reanchor();
      int nfs, nerr;
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      checks++;
      if (obs_phase !== 2'd1 || phase !== 2'd0) begin
         errors++; $display("FAIL early_reanchor: phase before=%0d after=%0d expected 1 0", obs_phase, phase);
      end
      idle3(nfs, nerr);
      step(1'b1, 1'b1);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL reanchor_not_yet: locked=%0b expected 0", locked); end
      idle3(nfs, nerr);
      step(1'b1, 1'b1);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL reanchor_lock: locked=%0b expected 1", locked); end
   endtask

   task automatic test_enable();
      int bad_out, bad_state;
      repeat (3) step(1'b0, 1'b1);
      checks++;
      if (phase !== 2'd3) begin errors++; $display("FAIL pre_freeze_phase: got %0d expected 3", phase); end
      bad_out   = 0;
      bad_state = 0;
      for (int i = 0; i < 5; i++) begin
         step((i % 2) == 0, 1'b0);
         if (obs_fs !== 1'b0 || obs_err !== 1'b0) bad_out++;
         if (phase !== 2'd3 || locked !== 1'b1) bad_state++;
      end
      checks++;
      if (bad_out != 0) begin errors++; $display("FAIL freeze_outputs: active cycles=%0d expected 0", bad_out); end
      checks++;
      if (bad_state != 0) begin errors++; $display("FAIL freeze_state: changed cycles=%0d expected 0", bad_state); end
      step(1'b1, 1'b1);
      checks++;
      if (obs_fs !== 1'b1 || obs_err !== 1'b0 || phase !== 2'd0 || locked !== 1'b1) begin
         errors++;
         $display("FAIL resume: frame_start=%0b err=%0b phase=%0d locked=%0b expected 1 0 0 1",
                  obs_fs, obs_err, phase, locked);
      end
   endtask

   task automatic test_async_reset();
      int nfs, nerr;
      step(1'b0, 1'b1);
`ifdef SYNC_LOCK_STATS_EN
      checks++;
      if (err_count !== 16'd4) begin errors++; $display("FAIL err_count_accum: got %0d expected 4", err_count); end
`endif
      rst = 1'b0;
      #2;
      checks++;
      if (locked !== 1'b0 || phase !== 2'd0) begin
         errors++; $display("FAIL async_reset: locked=%0b phase=%0d expected 0 0", locked, phase);
      end
`ifdef SYNC_LOCK_STATS_EN
      checks++;
      if (err_count !== 16'd0) begin errors++; $display("FAIL async_reset_err_count: got %0d expected 0", err_count); end
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(1'b1, 1'b1);
      idle3(nfs, nerr);
      step(1'b1, 1'b1);
      idle3(nfs, nerr);
      step(1'b1, 1'b1);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL relock_after_reset: locked=%0b expected 1", locked); end
`ifdef SYNC_LOCK_STATS_EN
      for (int i = 0; i < 5; i++) begin
         idle3(nfs, nerr);
         step((i % 2) == 1, 1'b1);
      end
      checks++;
      if (err_count !== 16'd3 || locked !== 1'b1) begin
         errors++; $display("FAIL three_misses: err_count=%0d locked=%0b expected 3 1", err_count, locked);
      end
`endif
   endtask

   initial begin
      clk     = 1'b0;
      rst     = 1'b0;
      en      = 1'b0;
      sync_in = 1'b0;
      errors  = 0;
      checks  = 0;
      test_reset();
      test_acquire();
      test_single_miss();
      test_double_miss();
      test_reanchor();
      test_enable();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
